apb_strb_ws_mem: RTL
====================

APB_STRB_WS_MEM -- requirements
Module: apb_strb_ws_mem

Interface
REQ-001 Parameter ADDR_W, default 10: width of paddr, which is a word address.
REQ-002 Parameter DATA_W, default 32: data width; SHALL be a multiple of 8, range 8..64.
REQ-003 Parameter DEPTH, default 768: number of implemented words; 1..2^ADDR_W.
REQ-004 Parameter WAIT, default 0: wait states per access phase; range 0..15.
REQ-005 Parameter PRIV_BASE, default DEPTH: first word address of the privileged region; writes at or above it need pprot[0]=1.
REQ-006 Port pclk, input, 1 bit: clock; all state changes on its rising edge.
REQ-007 Port preset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port psel, input, 1 bit: slave select.
REQ-009 Port penable, input, 1 bit: access-phase indicator.
REQ-010 Port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-011 Port paddr, input, ADDR_W bits: word address.
REQ-012 Port pwdata, input, DATA_W bits: write data.
REQ-013 Port pstrb, input, DATA_W/8 bits: byte-lane write strobes.
REQ-014 Port pprot, input, 3 bits: protection; only bit 0 (privileged) is used.
REQ-015 Port pready, output, 1 bit: transfer-complete indicator.
REQ-016 Port prdata, output, DATA_W bits: read data, registered.
REQ-017 Port pslverr, output, 1 bit: error response, valid only while pready=1 in ACCESS.

Function
REQ-018 The FSM SHALL have two states: IDLE and ACCESS, plus a 4-bit wait counter cnt.
REQ-019 IDLE -> ACCESS on an edge with psel=1 and penable=0 (setup phase): load cnt=WAIT, register err, and for reads register prdata.
REQ-020 err SHALL be 1 when paddr>=DEPTH, or when pwrite=1, paddr>=PRIV_BASE and pprot[0]=0.
REQ-021 Setup-phase read: prdata <= mem[paddr] if err=0, else prdata <= 0; setup-phase write leaves prdata unchanged.
REQ-022 In ACCESS: pready=0 while cnt!=0 (cnt decrements each edge); pready=1 when cnt=0.
REQ-023 pready SHALL be 1 in IDLE; pready is a combinational decode of state and cnt.
REQ-024 pslverr = err when in ACCESS with cnt=0, else 0.
REQ-025 Completion edge (ACCESS, cnt=0, psel=1, penable=1): if pwrite=1 and err=0, write each byte lane i with pstrb[i]=1 from pwdata; other lanes keep their value.
REQ-026 The FSM SHALL return to IDLE on the completion edge.
REQ-027 pstrb all-zero write completes with no memory change and pslverr=0 (if no err).
REQ-028 psel=0 while in ACCESS: abort, return to IDLE, no memory write, pslverr=0.
REQ-029 penable=1 with psel=1 seen in IDLE (no setup): ignore, stay IDLE, no write.
REQ-030 Back-to-back transfers: a setup phase on the edge after completion is accepted; zero idle cycles required.
REQ-031 Read latency: data valid on prdata at access phase start; total transfer = 2+WAIT cycles.
REQ-032 Memory contents are not reset; only control state and outputs are reset.

Reset
REQ-033 On preset_n=0, asynchronously: state=IDLE, cnt=0, err=0, prdata=0, pslverr=0, pready=1.
REQ-034 Reset asserted mid-ACCESS SHALL abort the transfer; no memory write occurs.
REQ-035 The first setup phase is accepted on the first rising edge after preset_n deasserts.

Verification
REQ-036 WAIT=0: write 0xDEADBEEF to addr 5 with pstrb=4'hF, then read addr 5 -> pready=1 in each access cycle, prdata=0xDEADBEEF, pslverr=0.
REQ-037 WAIT=2: write 0x11223344, then write 0xAABBCCDD with pstrb=4'b0101 to addr 7; read -> pready low for 2 access cycles each; read returns 0x11BB33DD.
REQ-038 DEPTH=768: write addr 800, then read addr 800 -> write ignored, pslverr=1 on the completion cycle, prdata=0.
REQ-039 PRIV_BASE=512: write addr 600 with pprot=0 -> pslverr=1, mem unchanged; same write with pprot=1 -> pslverr=0, data stored.
REQ-040 WAIT=3: drop psel after 1 access cycle; also assert preset_n=0 during a second ACCESS -> no write in either case; outputs reset immediately; next transfer completes normally.

Source files
------------

// File: rtl/apb_strb_ws_mem.sv
// APB slave memory with byte-lane write strobes, a fixed number of wait
// states per access, an out-of-range error response and a privileged
// upper region that only accepts writes carrying pprot[0]=1.
//
// Handshake: a transfer starts with a setup phase (psel=1, penable=0). The
// access phase follows (psel=1, penable=1) and completes on the first edge
// where pready=1. pready is high in IDLE and in ACCESS once the wait
// counter has reached zero. pslverr is meaningful only in that completing
// cycle. Dropping psel during ACCESS abandons the transfer without side
// effects.
module apb_strb_ws_mem #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 768,
  parameter int WAIT      = 0,
  parameter int PRIV_BASE = DEPTH
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  input  logic [2:0]            pprot,
  output logic                  pready,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pslverr
);

  localparam int NB = DATA_W / 8;
  // One extra bit so DEPTH/PRIV_BASE equal to 2^ADDR_W still compare cleanly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PRIV_L  = (ADDR_W+1)'(PRIV_BASE);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                err_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   prdata_q;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  logic                setup;
  logic                setup_err;
  logic                accept;
  logic                complete;

  // Only the privileged bit of pprot matters here.
  logic                unused_prot;
  assign unused_prot = ^pprot[2:1];

  assign setup     = psel & ~penable;
  assign setup_err = ({1'b0, paddr} >= DEPTH_L) |
                     (pwrite & ({1'b0, paddr} >= PRIV_L) & ~pprot[0]);
  assign accept    = (state_q == S_IDLE) & setup;
  assign complete  = (state_q == S_ACCESS) & (cnt_q == 4'd0) & psel & penable;

  // Next-state logic: count down wait states, finish or abandon the access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          state_d = S_ACCESS;
          cnt_d   = WAIT_L;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
        end else if (penable) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response outputs decoded directly from state and wait counter.
  always_comb begin
    pready  = (state_q == S_IDLE) | (cnt_q == 4'd0);
    pslverr = (state_q == S_ACCESS) & (cnt_q == 4'd0) & err_q;
    prdata  = prdata_q;
  end

  // Control state, captured transfer attributes and registered read data.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      prdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q   <= setup_err;
        write_q <= pwrite;
        addr_q  <= paddr;
        if (!pwrite) begin
          prdata_q <= setup_err ? '0 : mem[paddr];
        end
      end
    end
  end

  // Storage array is not reset; lanes with pstrb set are updated on completion.
  always_ff @(posedge pclk) begin
    if (complete && write_q && !err_q) begin
      for (int i = 0; i < NB; i++) begin
        if (pstrb[i]) begin
          mem[addr_q][i*8 +: 8] <= pwdata[i*8 +: 8];
        end
      end
    end
  end

endmodule
